axi_dma_rd_master: RTL

// AXI4 read-burst initiator that fetches a linear block from external memory (axi_sram_if

---
 rtl/axi_dma_rd_master_pkg.sv | 8 +
 rtl/axi_dma_rd_master_burst_calc.sv | 18 +
 rtl/axi_dma_rd_master.sv | 109 ++++++++++
 3 files changed

// File: rtl/axi_dma_rd_master_pkg.sv
// axi_dma_rd_master_pkg: shared AXI constants and FSM state encoding for the read DMA.
package axi_dma_rd_master_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
  localparam logic [12:0] BOUNDARY_4K   = 13'h1000;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
endpackage

// File: rtl/axi_dma_rd_master_burst_calc.sv
// axi_dma_rd_master_burst_calc: burst length = min(remaining, MAX_BURST, beats to 4KB edge).
module axi_dma_rd_master_burst_calc
  import axi_dma_rd_master_pkg::*;
#(
  parameter int AXI_WIDTH_DS = 4,
  parameter int MAX_BURST    = 16
) (
  input  logic [11:0] page_off,
  input  logic [23:0] remaining,
  output logic [7:0]  arlen
);
  localparam int SZ = $clog2(AXI_WIDTH_DS);
  logic [23:0] bnd, cap, len;
  assign bnd   = 24'((BOUNDARY_4K - {1'b0, page_off}) >> SZ);
  assign cap   = bnd < 24'(MAX_BURST) ? bnd : 24'(MAX_BURST);
  assign len   = remaining < cap ? remaining : cap;
  assign arlen = 8'(len - 24'd1);
endmodule

// File: rtl/axi_dma_rd_master.sv
// axi_dma_rd_master: single-outstanding AXI4 INCR read DMA streaming beats to a consumer.
module axi_dma_rd_master
  import axi_dma_rd_master_pkg::*;
#(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_DA = 32,
  parameter int AXI_WIDTH_DS = 4,
  parameter int MAX_BURST    = 16,
  parameter logic [AXI_WIDTH_ID-1:0] RD_ID = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_start,
  input  logic [AXI_WIDTH_AD-1:0] i_base_addr,
  input  logic [23:0]             i_num_beats,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  output logic [AXI_WIDTH_AD-1:0] M_ARADDR,
  output logic [AXI_WIDTH_ID-1:0] M_ARID,
  output logic [7:0]              M_ARLEN,
  output logic [2:0]              M_ARSIZE,
  output logic [1:0]              M_ARBURST,
  output logic [1:0]              M_ARLOCK,
  output logic [3:0]              M_ARCACHE,
  output logic [2:0]              M_ARPROT,
  input  logic                    M_RVALID,
  output logic                    M_RREADY,
  input  logic [AXI_WIDTH_DA-1:0] M_RDATA,
  input  logic                    M_RLAST,
  input  logic [AXI_WIDTH_ID-1:0] M_RID,
  input  logic [1:0]              M_RRESP,
  output logic [AXI_WIDTH_DA-1:0] o_data,
  output logic                    o_valid,
  input  logic                    i_ready
);
  localparam int SZ = $clog2(AXI_WIDTH_DS);
  state_t state, state_nxt;
  logic [AXI_WIDTH_AD-1:0] ar_addr, base_al, next_addr, calc_addr;
  logic [7:0] ar_len, beat_cnt, calc_len;
  logic [23:0] rem, calc_rem;
  logic err, beat, last_beat, start_ok, bad;
  assign base_al   = i_base_addr & ~AXI_WIDTH_AD'(AXI_WIDTH_DS - 1);
  assign next_addr = ar_addr + (AXI_WIDTH_AD'({1'b0, ar_len} + 9'd1) << SZ);
  assign start_ok  = state == IDLE && i_start;
  assign beat      = M_RVALID && M_RREADY;
  assign last_beat = beat && beat_cnt == ar_len;
  assign bad       = M_RRESP != AXI_RESP_OKAY || M_RID != RD_ID || M_RLAST != (beat_cnt == ar_len);
  // In IDLE the calculator sizes the first burst; otherwise it sizes the one after the current burst.
  assign calc_addr = state == IDLE ? base_al : next_addr;
  assign calc_rem  = state == IDLE ? i_num_beats : rem - 24'd1;
  axi_dma_rd_master_burst_calc #(.AXI_WIDTH_DS(AXI_WIDTH_DS), .MAX_BURST(MAX_BURST)) u_calc (
    .page_off (calc_addr[11:0]),
    .remaining(calc_rem),
    .arlen    (calc_len)
  );
  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (i_start ? (i_num_beats == 24'd0 ? DONE : ADDR) : IDLE)
              : state == ADDR ? (M_ARREADY ? DATA : ADDR)
              : state == DATA ? (last_beat ? (rem == 24'd1 ? DONE : ADDR) : DATA)
              : IDLE;
    o_busy    = state != IDLE;
    o_done    = state == DONE;
    M_ARVALID = state == ADDR;
    M_RREADY  = state == DATA && i_ready;
    o_valid   = state == DATA && M_RVALID;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      ar_addr  <= '0;
      ar_len   <= '0;
      beat_cnt <= '0;
      rem      <= '0;
      err      <= 1'b0;
    end else begin
      if (start_ok) begin
        ar_addr  <= base_al;
        ar_len   <= calc_len;
        rem      <= i_num_beats;
        beat_cnt <= '0;
        err      <= 1'b0;
      end
      if (beat) begin
        rem      <= rem - 24'd1;
        beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
        err      <= err | bad;
      end
      if (last_beat && rem != 24'd1) begin
        ar_addr <= next_addr;
        ar_len  <= calc_len;
      end
    end
  assign o_err     = err;
  assign M_ARADDR  = ar_addr;
  assign M_ARLEN   = ar_len;
  assign M_ARID    = RD_ID;
  assign M_ARSIZE  = 3'(SZ);
  assign M_ARBURST = AXI_BURST_INCR;
  assign M_ARLOCK  = 2'b00;
  assign M_ARCACHE = AXI_CACHE_DEF;
  assign M_ARPROT  = 3'b000;
  assign o_data    = M_RDATA;
endmodule
